ws2812_framebuf: RTL and testbench
==================================

WS2812_FRAMEBUF -- requirements
Module: ws2812_framebuf

Interface
REQ-001 Parameter W_ADDR, default 6, SHALL set the pixel address width (64 LEDs).
REQ-002 Parameter W_DATA, default 24, SHALL set the pixel word width (raw GRB; no reordering).
REQ-003 clk  in  1  SHALL be the single system clock (100 MHz); all logic is on posedge clk.
REQ-004 rst_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 wr_en  in  1  SHALL be the host write strobe, one write per cycle.
REQ-006 wr_addr  in  W_ADDR  SHALL be the back-bank pixel address.
REQ-007 wr_data  in  W_DATA  SHALL be the back-bank pixel value.
REQ-008 clear_req  in  1  SHALL be a one-cycle pulse that requests a zero-fill of the back bank.
REQ-009 swap_req  in  1  SHALL be a one-cycle pulse that requests a front/back bank exchange.
REQ-010 frame_sync  in  1  SHALL be a one-cycle pulse from the driver marking the latch gap between frames.
REQ-011 busy  out  1  SHALL be high while a clear is running or a swap is pending.
REQ-012 swap_ack  out  1  SHALL be a one-cycle pulse on the cycle the swap takes effect.
REQ-013 rd_start  in  1  SHALL be the driver read request (level; may originate from a divided-clock domain).
REQ-014 rd_addr  in  W_ADDR  SHALL be the front-bank pixel address, stable while rd_start is high.
REQ-015 rd_data  out  W_DATA  SHALL be the front-bank pixel value.
REQ-016 rd_done  out  1  SHALL be a one-cycle pulse marking rd_data valid.

Function
REQ-017 The block SHALL hold two banks of 2^W_ADDR x W_DATA; a bank-select flop `front` SHALL decide which bank is read and which is written.
REQ-018 rd_start SHALL pass through a 2-flop synchronizer; a request SHALL be the rising edge seen at the synchronizer output.
REQ-019 rd_done SHALL assert exactly 4 clk edges after the first edge that samples rd_start high, for exactly 1 cycle.
REQ-020 rd_data SHALL equal front[rd_addr] while rd_done is high, and SHALL hold until the next request completes.
REQ-021 A held-high rd_start SHALL produce one request only; a new request requires rd_start low for at least 2 cycles.
REQ-022 FSM states SHALL be IDLE, CLEAR and SWAP_WAIT.
REQ-023 In IDLE, wr_en SHALL write wr_data to back[wr_addr] at the next edge.
REQ-024 IDLE + clear_req SHALL go to CLEAR; CLEAR SHALL write zero to back addresses 0..2^W_ADDR-1, one per cycle, then return to IDLE (64 cycles at defaults).
REQ-025 IDLE + swap_req SHALL go to SWAP_WAIT; on the next frame_sync, `front` SHALL toggle, swap_ack SHALL pulse in the same cycle, and the FSM SHALL return to IDLE.
REQ-026 A swap_req during CLEAR SHALL be latched and SHALL enter SWAP_WAIT immediately after CLEAR completes.
REQ-027 wr_en SHALL be ignored in CLEAR and SWAP_WAIT; clear_req SHALL be ignored outside IDLE.
REQ-028 If clear_req and swap_req arrive in the same IDLE cycle, clear SHALL run first, then the swap.
REQ-029 A frame_sync outside SWAP_WAIT SHALL have no effect; extra swap_req pulses in SWAP_WAIT SHALL be absorbed, giving one swap.
REQ-030 A read in flight when `front` toggles SHALL return data from the bank selected when the request was detected.
REQ-031 The clear address counter SHALL wrap to 0 at the end of CLEAR and SHALL not be reused elsewhere.

Reset
REQ-032 While rst_n is low, the block SHALL hold FSM=IDLE, front=0, busy=0, swap_ack=0, rd_done=0, rd_data=0, the synchronizer flops at 0 and the pending swap cleared.
REQ-033 Bank RAM contents SHALL NOT be reset; an asserted reset mid-CLEAR or mid-read SHALL abort the operation with no further writes and no rd_done.

Structure
REQ-034 The FSM state encodings and the colour constants (black 24'h000000, test colours) SHALL live in shared package ws2812_pkg.
REQ-035 The block SHALL contain one sub-module, ws2812_bank_ram: a simple dual-port RAM (1 write, 1 registered read) instantiated twice and mappable to SB_RAM40_4K.

Verification
REQ-036 The bench SHALL cover: write 24'h0F0101 to address 5, swap_req, frame_sync, read address 5 -> swap_ack pulse and rd_data=24'h0F0101 with rd_done 4 edges after rd_start rises.
REQ-037 The bench SHALL cover: clear_req, then wr_en to address 3 on the next cycle -> write dropped, busy high 64 cycles, and after a swap every address reads 0.
REQ-038 The bench SHALL cover: swap_req with no frame_sync for 1000 cycles -> busy stays 1, no swap_ack, reads still return the old bank.
REQ-039 The bench SHALL cover: clear_req and swap_req in the same cycle -> 64 clear cycles, then SWAP_WAIT, one swap_ack on the next frame_sync.
REQ-040 The bench SHALL cover: rd_start held high for 20 cycles -> exactly one rd_done.
REQ-041 The bench SHALL cover: rst_n low at clear cycle 10, then high -> busy=0, FSM IDLE, addresses 10..63 keep their prior values.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared encodings for the WS2812 frame buffer: FSM states and GRB colour constants.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_WAIT = 2'd2
    } fb_state_t;

    // Colours are raw GRB words, exactly as shifted out to the LED string.
    localparam logic [23:0] COLOR_BLACK      = 24'h000000;
    localparam logic [23:0] COLOR_TEST_RED   = 24'h00FF00;
    localparam logic [23:0] COLOR_TEST_GREEN = 24'hFF0000;
    localparam logic [23:0] COLOR_TEST_BLUE  = 24'h0000FF;
    localparam logic [23:0] COLOR_TEST_DIM   = 24'h0F0101;

endpackage

// File: rtl/ws2812_bank_ram.sv
// One pixel bank: simple dual-port RAM, single write port, registered read port.
module ws2812_bank_ram #(
    parameter int W_ADDR = 6,
    parameter int W_DATA = 24
) (
    input  logic              clk,
    input  logic              we,
    input  logic [W_ADDR-1:0] waddr,
    input  logic [W_DATA-1:0] wdata,
    input  logic              re,
    input  logic [W_ADDR-1:0] raddr,
    output logic [W_DATA-1:0] rdata
);

    localparam int DEPTH = 1 << W_ADDR;

    logic [W_DATA-1:0] mem [0:DEPTH-1];

    // No reset on the array or the read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ws2812_framebuf.sv
// Double-buffered WS2812 frame buffer: host fills the back bank, the LED driver
// reads the front bank, and banks exchange only in the latch gap between frames.
module ws2812_framebuf
    import ws2812_pkg::*;
#(
    parameter int W_ADDR = 6,
    parameter int W_DATA = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [W_ADDR-1:0] wr_addr,
    input  logic [W_DATA-1:0] wr_data,
    input  logic              clear_req,
    input  logic              swap_req,
    input  logic              frame_sync,
    output logic              busy,
    output logic              swap_ack,
    input  logic              rd_start,
    input  logic [W_ADDR-1:0] rd_addr,
    output logic [W_DATA-1:0] rd_data,
    output logic              rd_done
);

    localparam logic [W_ADDR-1:0] LAST_ADDR = '1;

    fb_state_t         state, state_nxt;
    logic              front;
    logic              swap_pend, swap_pend_nxt;
    logic              do_swap;
    logic [W_ADDR-1:0] clr_addr;

    logic              bank_we;
    logic [W_ADDR-1:0] bank_waddr;
    logic [W_DATA-1:0] bank_wdata;

    logic [1:0]        rd_sync;
    logic              rd_sync_q;
    logic              rd_req;
    logic              rd_p1, rd_p2;
    logic              rd_bank_p1, rd_bank_p2;
    logic [W_DATA-1:0] q0, q1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            swap_pend <= 1'b0;
            clr_addr  <= '0;
            front     <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            state     <= state_nxt;
            swap_pend <= swap_pend_nxt;
            front     <= front ^ do_swap;
            swap_ack  <= do_swap;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    // A swap requested while clearing is parked in swap_pend and taken once the fill ends.
    always_comb begin
        state_nxt     = state;
        swap_pend_nxt = swap_pend;
        do_swap       = 1'b0;
        bank_we       = 1'b0;
        bank_waddr    = wr_addr;
        bank_wdata    = wr_data;
        case (state)
            IDLE: begin
                bank_we = wr_en;
                if (clear_req) begin
                    state_nxt     = CLEAR;
                    swap_pend_nxt = swap_req;
                end else if (swap_req) begin
                    state_nxt = SWAP_WAIT;
                end
            end
            CLEAR: begin
                bank_we    = 1'b1;
                bank_waddr = clr_addr;
                bank_wdata = W_DATA'(COLOR_BLACK);
                if (swap_req) begin
                    swap_pend_nxt = 1'b1;
                end
                if (clr_addr == LAST_ADDR) begin
                    state_nxt     = (swap_pend || swap_req) ? SWAP_WAIT : IDLE;
                    swap_pend_nxt = 1'b0;
                end
            end
            SWAP_WAIT: begin
                if (frame_sync) begin
                    do_swap   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // rd_req fires on the synchronized rising edge; the bank is frozen one cycle later.
    assign rd_req = rd_sync[1] & ~rd_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sync    <= 2'b00;
            rd_sync_q  <= 1'b0;
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            rd_bank_p1 <= 1'b0;
            rd_bank_p2 <= 1'b0;
            rd_done    <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_sync   <= {rd_sync[0], rd_start};
            rd_sync_q <= rd_sync[1];
            rd_p1     <= rd_req;
            rd_p2     <= rd_p1;
            rd_done   <= rd_p2;
            if (rd_req) begin
                rd_bank_p1 <= front;
            end
            rd_bank_p2 <= rd_bank_p1;
            if (rd_p2) begin
                rd_data <= rd_bank_p2 ? q1 : q0;
            end
        end
    end

    ws2812_bank_ram #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) u_bank0 (
        .clk   (clk),
        .we    (bank_we & front),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .re    (rd_p1),
        .raddr (rd_addr),
        .rdata (q0)
    );

    ws2812_bank_ram #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) u_bank1 (
        .clk   (clk),
        .we    (bank_we & ~front),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .re    (rd_p1),
        .raddr (rd_addr),
        .rdata (q1)
    );

endmodule

// File: tb/tb_ws2812_framebuf.sv
// Self-checking bench for ws2812_framebuf: behavioural bank/swap/read model plus directed scenarios.
module tb_ws2812_framebuf;
    import ws2812_pkg::*;

    localparam int W_ADDR = 6;
    localparam int W_DATA = 24;
    localparam int DEPTH  = 64;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              wr_en      = 1'b0;
    logic [W_ADDR-1:0] wr_addr    = '0;
    logic [W_DATA-1:0] wr_data    = '0;
    logic              clear_req  = 1'b0;
    logic              swap_req   = 1'b0;
    logic              frame_sync = 1'b0;
    logic              rd_start   = 1'b0;
    logic [W_ADDR-1:0] rd_addr    = '0;
    logic              busy, swap_ack, rd_done;
    logic [W_DATA-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ws2812_framebuf #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .swap_req   (swap_req),
        .frame_sync (frame_sync),
        .busy       (busy),
        .swap_ack   (swap_ack),
        .rd_start   (rd_start),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_done    (rd_done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: two banks, a front pointer, and a list of pending reads due 4 edges out.
    typedef enum {M_IDLE, M_CLEAR, M_WAIT} mode_t;
    typedef struct {int due; int addr; int bank;} rd_item_t;

    logic [W_DATA-1:0] m_mem   [2][DEPTH];
    bit                m_known [2][DEPTH];
    mode_t             m_mode       = M_IDLE;
    int                m_front      = 0;
    int                m_cleared    = 0;
    int                m_cyc        = 0;
    bit                m_pend       = 1'b0;
    bit                m_prev_rd    = 1'b0;
    rd_item_t          m_q[$];
    bit                e_busy       = 1'b0;
    bit                e_ack        = 1'b0;
    bit                e_done       = 1'b0;
    bit                e_data_known = 1'b1;
    logic [W_DATA-1:0] e_data       = '0;

    task automatic modelWrite(input int b, input int a, input logic [W_DATA-1:0] d);
        m_mem[b][a]   = d;
        m_known[b][a] = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode       = M_IDLE;
            m_front      = 0;
            m_pend       = 1'b0;
            m_prev_rd    = 1'b0;
            m_q.delete();
            e_busy       = 1'b0;
            e_ack        = 1'b0;
            e_done       = 1'b0;
            e_data       = '0;
            e_data_known = 1'b1;
        end else begin
            m_cyc++;
            e_ack  = 1'b0;
            e_done = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (wr_en) modelWrite(1 - m_front, int'(wr_addr), wr_data);
                    if (clear_req) begin
                        m_mode    = M_CLEAR;
                        m_cleared = 0;
                        m_pend    = swap_req;
                    end else if (swap_req) begin
                        m_mode = M_WAIT;
                    end
                end
                M_CLEAR: begin
                    modelWrite(1 - m_front, m_cleared, '0);
                    m_cleared++;
                    if (swap_req) m_pend = 1'b1;
                    if (m_cleared == DEPTH) begin
                        m_mode = m_pend ? M_WAIT : M_IDLE;
                        m_pend = 1'b0;
                    end
                end
                M_WAIT: begin
                    if (frame_sync) begin
                        m_front = 1 - m_front;
                        e_ack   = 1'b1;
                        m_mode  = M_IDLE;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
            e_busy = (m_mode != M_IDLE);
            if (rd_start && !m_prev_rd)
                m_q.push_back('{due: m_cyc + 4, addr: int'(rd_addr), bank: m_front});
            m_prev_rd = rd_start;
            if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
                e_done       = 1'b1;
                e_data       = m_mem[m_q[0].bank][m_q[0].addr];
                e_data_known = m_known[m_q[0].bank][m_q[0].addr];
                void'(m_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("busy", 32'(busy), 32'(e_busy));
        checkOutput("swap_ack", 32'(swap_ack), 32'(e_ack));
        checkOutput("rd_done", 32'(rd_done), 32'(e_done));
        if (e_data_known) checkOutput("rd_data", 32'(rd_data), 32'(e_data));
    end

    // Advances N cycles; one-shot strobes drop after the first edge samples them.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            wr_en      = 1'b0;
            clear_req  = 1'b0;
            swap_req   = 1'b0;
            frame_sync = 1'b0;
        end
    endtask

    task automatic writePixel(input int a, input logic [W_DATA-1:0] d);
        wr_en   = 1'b1;
        wr_addr = W_ADDR'(a);
        wr_data = d;
        applyStimulus(1);
    endtask

    task automatic doSwap();
        swap_req = 1'b1;
        applyStimulus(3);
        frame_sync = 1'b1;
        applyStimulus(1);
        checkOutput("swap_ack_pulse", 32'(swap_ack), 32'd1);
    endtask

    task automatic readPixel(input int a, output logic [W_DATA-1:0] d, output int edges_after);
        int first_done;
        first_done = -1;
        d          = '0;
        rd_addr    = W_ADDR'(a);
        rd_start   = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1);
            if (rd_done && first_done < 0) begin
                first_done = k;
                d          = rd_data;
            end
        end
        rd_start = 1'b0;
        applyStimulus(3);
        edges_after = first_done - 1;
    endtask

    function automatic logic [W_DATA-1:0] pattern(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, b ^ 8'h5A};
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W_DATA-1:0] d;
        int lat, busy_cnt, ack_cnt, done_cnt;

        applyStimulus(3);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_swap_ack", 32'(swap_ack), 32'd0);
        checkOutput("reset_rd_done", 32'(rd_done), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        applyStimulus(2);

        $display("[TB] write, swap, read back");
        writePixel(5, COLOR_TEST_DIM);
        doSwap();
        readPixel(5, d, lat);
        checkOutput("dim_read_data", 32'(d), 32'h0F0101);
        checkOutput("dim_read_latency", 32'(lat), 32'd4);

        $display("[TB] clear with dropped write");
        clear_req = 1'b1;
        applyStimulus(1);
        busy_cnt = int'(busy);
        wr_en    = 1'b1;
        wr_addr  = 6'd3;
        wr_data  = COLOR_TEST_GREEN;
        for (int n = 0; n < 80; n++) begin
            applyStimulus(1);
            busy_cnt += int'(busy);
        end
        checkOutput("clear_busy_cycles", 32'(busy_cnt), 32'd64);
        doSwap();
        for (int a = 0; a < DEPTH; a++) begin
            readPixel(a, d, lat);
            checkOutput("cleared_read", 32'(d), 32'd0);
        end

        $display("[TB] swap held without frame_sync");
        writePixel(7, COLOR_TEST_BLUE);
        swap_req = 1'b1;
        applyStimulus(1);
        busy_cnt = 0;
        ack_cnt  = 0;
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(1);
            busy_cnt += int'(busy);
            ack_cnt  += int'(swap_ack);
        end
        checkOutput("stall_busy_cycles", 32'(busy_cnt), 32'd1000);
        checkOutput("stall_ack_count", 32'(ack_cnt), 32'd0);
        readPixel(3, d, lat);
        checkOutput("stall_old_bank", 32'(d), 32'd0);
        checkOutput("stall_busy_after_read", 32'(busy), 32'd1);
        frame_sync = 1'b1;
        applyStimulus(1);
        checkOutput("stall_swap_ack", 32'(swap_ack), 32'd1);
        readPixel(7, d, lat);
        checkOutput("new_bank_blue", 32'(d), 32'h0000FF);
        readPixel(5, d, lat);
        checkOutput("new_bank_dim", 32'(d), 32'h0F0101);

        $display("[TB] clear and swap together");
        clear_req = 1'b1;
        swap_req  = 1'b1;
        applyStimulus(1);
        busy_cnt = int'(busy);
        ack_cnt  = int'(swap_ack);
        for (int n = 2; n <= 120; n++) begin
            if (n == 31) frame_sync = 1'b1;
            if (n == 71) swap_req = 1'b1;
            if (n == 81) frame_sync = 1'b1;
            applyStimulus(1);
            busy_cnt += int'(busy);
            ack_cnt  += int'(swap_ack);
        end
        checkOutput("combo_busy_cycles", 32'(busy_cnt), 32'd80);
        checkOutput("combo_ack_count", 32'(ack_cnt), 32'd1);

        $display("[TB] held rd_start");
        rd_addr  = 6'd9;
        rd_start = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1);
            done_cnt += int'(rd_done);
        end
        rd_start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1);
            done_cnt += int'(rd_done);
        end
        checkOutput("held_read_done_count", 32'(done_cnt), 32'd1);

        $display("[TB] reset during clear");
        for (int a = 0; a < DEPTH; a++) writePixel(a, pattern(a));
        clear_req = 1'b1;
        applyStimulus(1);
        applyStimulus(10);
        rst_n = 1'b0;
        applyStimulus(3);
        rst_n = 1'b1;
        applyStimulus(1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rd_data", 32'(rd_data), 32'd0);
        applyStimulus(80);
        checkOutput("abort_stays_idle", 32'(busy), 32'd0);
        doSwap();
        for (int a = 0; a < DEPTH; a++) begin
            readPixel(a, d, lat);
            checkOutput("abort_read", 32'(d), (a < 10) ? 32'd0 : 32'(pattern(a)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
